// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot/debug loader.
// Optional feature macro: UART_LOADER_CHKSUM_EN (load replies with a byte checksum).
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    BYTE  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4,
    STEP  = 3'd5,
    REPLY = 3'd6
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  // States in which the receive FIFO may be popped.
  function automatic logic is_pop_state(input state_t s);
    return (s == IDLE) || (s == LEN) || (s == BYTE);
  endfunction

endpackage

// File: rtl/uart_loader_ctrl_word_assembler.sv
// Little-endian byte-lane assembler: four pushes build one instruction word.
module word_assembler #(
  parameter int N_BIT  = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [N_BIT-1:0]  din,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] word_r;
  logic [1:0]        idx_r;

  // Lane register and byte index; clr drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      idx_r  <= 2'd0;
    end else if (clr) begin
      word_r <= '0;
      idx_r  <= 2'd0;
    end else if (push) begin
      word_r[32'(idx_r) * N_BIT +: N_BIT] <= din;
      idx_r                               <= idx_r + 2'd1;
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
    end
  end

  assign word       = word_r;
  assign word_ready = push & (idx_r == 2'd3);

endmodule

// File: rtl/uart_loader_ctrl.sv
// UART command sequencer: loads instruction memory, runs/steps the CPU, replies one byte.
// Optional feature macro: UART_LOADER_CHKSUM_EN (load completion replies with modulo sum).
module uart_loader_ctrl
  import uart_loader_pkg::*;
#(
  parameter int N_BIT  = 8,
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_empty,
  input  logic [N_BIT-1:0]  r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [N_BIT-1:0]  w_data,
  output logic              wr_uart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              cpu_step,
  input  logic              cpu_halted,
  output logic              busy
);

  state_t             state_r, state_s;
  logic [N_BIT-1:0]   cnt_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [N_BIT-1:0]   w_data_r, reply_s;
  logic [N_BIT-1:0]   len0_reply_s, load_reply_s;
  logic               rd_en_r, tx_en_r, we_r, run_r, step_r, busy_r;
  logic               pop_s, clr_s, push_s, word_ready_s;

  // Handshakes gate a registered enable with the live FIFO flag so a pop or
  // push never happens on an empty/full FIFO and bytes can stream every cycle.
  assign pop_s   = rd_en_r & ~rx_empty;
  assign rd_uart = pop_s;
  assign wr_uart = tx_en_r & ~tx_full;

  word_assembler #(.N_BIT(N_BIT), .WORD_W(WORD_W)) u_asm (
    .clk        (CLK),
    .rst_n      (RESET),
    .clr        (clr_s),
    .push       (push_s),
    .din        (r_data),
    .word       (imem_wdata),
    .word_ready (word_ready_s)
  );

`ifdef UART_LOADER_CHKSUM_EN
  logic [N_BIT-1:0] sum_r;

  // Running modulo sum of the count byte and every data byte.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sum_r <= '0;
    end else if ((state_r == LEN) && pop_s) begin
      sum_r <= r_data;
    end else if ((state_r == BYTE) && pop_s) begin
      sum_r <= sum_r + r_data;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign len0_reply_s = r_data;
  assign load_reply_s = sum_r;
`else
  assign len0_reply_s = N_BIT'(ACK);
  assign load_reply_s = N_BIT'(ACK);
`endif

  // Next-state decode and reply-byte selection.
  always_comb begin
    state_s = state_r;
    reply_s = w_data_r;
    clr_s   = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          if (r_data == N_BIT'(CMD_LOAD)) begin
            state_s = LEN;
          end else if (r_data == N_BIT'(CMD_RUN)) begin
            state_s = RUN;
          end else if (r_data == N_BIT'(CMD_STEP)) begin
            state_s = STEP;
          end else begin
            state_s = REPLY;
            reply_s = N_BIT'(NAK);
          end
        end else begin
          state_s = IDLE;
        end
      end
      LEN: begin
        if (pop_s) begin
          clr_s = 1'b1;
          if (r_data == '0) begin
            state_s = REPLY;
            reply_s = len0_reply_s;
          end else begin
            state_s = BYTE;
          end
        end else begin
          state_s = LEN;
        end
      end
      BYTE: begin
        if (pop_s) begin
          push_s = 1'b1;
          if (word_ready_s) begin
            state_s = WRITE;
          end else begin
            state_s = BYTE;
          end
        end else begin
          state_s = BYTE;
        end
      end
      WRITE: begin
        if (cnt_r == N_BIT'(1)) begin
          state_s = REPLY;
          reply_s = load_reply_s;
        end else begin
          state_s = BYTE;
        end
      end
      RUN: begin
        if (cpu_halted) begin
          state_s = REPLY;
          reply_s = N_BIT'(ACK);
        end else begin
          state_s = RUN;
        end
      end
      STEP: begin
        state_s = REPLY;
        reply_s = N_BIT'(ACK);
      end
      REPLY: begin
        if (!tx_full) begin
          state_s = IDLE;
        end else begin
          state_s = REPLY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Word counter and write address; the address only moves after a write cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r  <= '0;
      addr_r <= '0;
    end else if ((state_r == LEN) && pop_s) begin
      cnt_r  <= r_data;
      addr_r <= '0;
    end else if (state_r == WRITE) begin
      cnt_r  <= cnt_r - N_BIT'(1);
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      cnt_r  <= cnt_r;
      addr_r <= addr_r;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_en_r  <= 1'b0;
      tx_en_r  <= 1'b0;
      we_r     <= 1'b0;
      run_r    <= 1'b0;
      step_r   <= 1'b0;
      busy_r   <= 1'b0;
      w_data_r <= '0;
    end else begin
      rd_en_r  <= is_pop_state(state_s);
      tx_en_r  <= (state_s == REPLY);
      we_r     <= (state_s == WRITE);
      run_r    <= (state_s == RUN);
      step_r   <= (state_s == STEP);
      busy_r   <= (state_s != IDLE);
      w_data_r <= reply_s;
    end
  end

  assign w_data    = w_data_r;
  assign imem_we   = we_r;
  assign imem_addr = addr_r;
  assign cpu_run   = run_r;
  assign cpu_step  = step_r;
  assign busy      = busy_r;

endmodule
